// File: rtl/tmds_multimode_encoder.sv
// tmds_multimode_encoder: one HDMI lane of TMDS video, control, TERC4 and guard-band symbols with a fixed pipeline latency
module tmds_multimode_encoder #(
    parameter int CHANNEL = 0,
    parameter int LATENCY = 4
) (
    input  logic              i_hdmi_clk,
    input  logic              i_reset,
    input  logic [2:0]        i_mode,
    input  logic [7:0]        i_data,
    input  logic [1:0]        i_ctrl,
    input  logic [3:0]        i_terc4,
    output logic [9:0]        o_tmds,
    output logic signed [5:0] o_disparity,
    output logic              o_mode_err
);
    localparam logic [2:0] M_VIDEO  = 3'd1;
    localparam logic [2:0] M_VGUARD = 3'd2;
    localparam logic [2:0] M_IGUARD = 3'd3;
    localparam logic [2:0] M_TERC4  = 3'd4;
    localparam logic [9:0] GUARD_A  = 10'b1011001100;
    localparam logic [9:0] GUARD_B  = 10'b0100110011;
    localparam logic [9:0] CTRL_CODE [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    localparam logic [9:0] TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    typedef struct packed {
        logic [2:0] mode;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic [3:0] terc4;
    } in_t;
    in_t               pipe_q [LATENCY-2];
    in_t               s;
    logic [3:0]        n1;
    logic              xn;
    logic [8:0]        qm_d, qm_q;
    logic signed [5:0] diff_d, diff_q;
    logic              vid_d, vid_q, err_d, err_q, err_out_q;
    logic [9:0]        sym_d, sym_q, tmds_d, tmds_q;
    logic signed [5:0] cnt_d, cnt_q, adj;
    logic              zero, inv;
    always_ff @(posedge i_hdmi_clk) begin
        if (i_reset) begin
            for (int i = 0; i < LATENCY - 2; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {i_mode, i_data, i_ctrl, i_terc4};
            for (int i = 1; i < LATENCY - 2; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end
    assign s     = pipe_q[LATENCY-3];
    assign vid_d = s.mode == M_VIDEO;
    assign err_d = s.mode > M_TERC4;
    always_comb begin
        n1 = 4'($countones(s.data));
        xn = n1 > 4'd4 || (n1 == 4'd4 && !s.data[0]);
        qm_d = '0;
        qm_d[0] = s.data[0];
        for (int i = 1; i < 8; i++) qm_d[i] = qm_d[i-1] ^ s.data[i] ^ xn;
        qm_d[8] = ~xn;
        diff_d = $signed({1'b0, 4'($countones(qm_d[7:0])), 1'b0}) - 6'sd8;
        sym_d = s.mode == M_VGUARD ? (CHANNEL == 1 ? GUARD_B : GUARD_A)
              : s.mode == M_IGUARD ? (CHANNEL == 0 ? TERC4_CODE[{2'b11, s.ctrl}] : GUARD_B)
              : s.mode == M_TERC4  ? TERC4_CODE[s.terc4]
              : CTRL_CODE[s.ctrl];
    end
    always_ff @(posedge i_hdmi_clk) begin
        if (i_reset) begin
            qm_q   <= '0;
            diff_q <= '0;
            vid_q  <= 1'b0;
            err_q  <= 1'b0;
            sym_q  <= CTRL_CODE[0];
        end else begin
            qm_q   <= qm_d;
            diff_q <= diff_d;
            vid_q  <= vid_d;
            err_q  <= err_d;
            sym_q  <= sym_d;
        end
    end
    // inv: invert q_m[7:0]; adj: the +/-2 term that only applies outside the balanced case
    always_comb begin
        zero   = cnt_q == 6'sd0 || diff_q == 6'sd0;
        inv    = zero ? ~qm_q[8] : cnt_q[5] == diff_q[5];
        adj    = zero ? 6'sd0 : inv ? (qm_q[8] ? 6'sd2 : 6'sd0) : (qm_q[8] ? 6'sd0 : -6'sd2);
        tmds_d = vid_q ? {inv, qm_q[8], inv ? ~qm_q[7:0] : qm_q[7:0]} : sym_q;
        cnt_d  = vid_q ? cnt_q + (inv ? -diff_q : diff_q) + adj : 6'sd0;
    end
    always_ff @(posedge i_hdmi_clk) begin
        if (i_reset) begin
            tmds_q    <= CTRL_CODE[0];
            cnt_q     <= '0;
            err_out_q <= 1'b0;
        end else begin
            tmds_q    <= tmds_d;
            cnt_q     <= cnt_d;
            err_out_q <= err_q;
        end
    end
    assign o_tmds      = tmds_q;
    assign o_disparity = cnt_q;
    assign o_mode_err  = err_out_q;
endmodule

// File: tb/tb_tmds_multimode_encoder.sv
// tb_tmds_multimode_encoder: vector table, directed reset sequences and random stimulus against an arithmetic lane model
module tb_tmds_multimode_encoder;
    localparam int NU = 4;
    localparam int LAT [NU] = '{4, 4, 3, 7};
    localparam int CH  [NU] = '{0, 1, 2, 0};
    localparam logic [9:0] G0 = 10'b1011001100;
    localparam logic [9:0] G1 = 10'b0100110011;
    localparam logic [9:0] CC [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    localparam logic [9:0] T4 [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    typedef struct packed {
        logic [9:0]        tmds;
        logic signed [5:0] disp;
        logic              err;
    } sym_t;
    typedef struct {
        logic [2:0]        m;
        logic [7:0]        d;
        logic [1:0]        c;
        logic [3:0]        t;
        logic [9:0]        x;
        logic signed [5:0] p;
        logic              e;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] mode = '0;
    logic [7:0] data = '0;
    logic [1:0] ctrl = '0;
    logic [3:0] terc = '0;
    logic [9:0]        tm [NU];
    logic signed [5:0] dp [NU];
    logic              er [NU];
    sym_t pipe [NU][16];
    int cnt = 0;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit armed = 0;
    vec_t tbl [17];
    always #5 clk = ~clk;
    tmds_multimode_encoder #(.CHANNEL(0), .LATENCY(4)) u0 (.i_hdmi_clk(clk), .i_reset(rst), .i_mode(mode), .i_data(data),
        .i_ctrl(ctrl), .i_terc4(terc), .o_tmds(tm[0]), .o_disparity(dp[0]), .o_mode_err(er[0]));
    tmds_multimode_encoder #(.CHANNEL(1), .LATENCY(4)) u1 (.i_hdmi_clk(clk), .i_reset(rst), .i_mode(mode), .i_data(data),
        .i_ctrl(ctrl), .i_terc4(terc), .o_tmds(tm[1]), .o_disparity(dp[1]), .o_mode_err(er[1]));
    tmds_multimode_encoder #(.CHANNEL(2), .LATENCY(3)) u2 (.i_hdmi_clk(clk), .i_reset(rst), .i_mode(mode), .i_data(data),
        .i_ctrl(ctrl), .i_terc4(terc), .o_tmds(tm[2]), .o_disparity(dp[2]), .o_mode_err(er[2]));
    tmds_multimode_encoder #(.CHANNEL(0), .LATENCY(7)) u3 (.i_hdmi_clk(clk), .i_reset(rst), .i_mode(mode), .i_data(data),
        .i_ctrl(ctrl), .i_terc4(terc), .o_tmds(tm[3]), .o_disparity(dp[3]), .o_mode_err(er[3]));
    function automatic sym_t enc(input int ch, input logic [2:0] m, input logic [7:0] d, input logic [1:0] c,
                                 input logic [3:0] t, input int cin, output int cout);
        sym_t s;
        logic [7:0] qm;
        logic xn, q8;
        int a, b;
        cout = 0;
        s.err = m > 3'd4;
        case (m)
            3'd1: begin
                a = $countones(d);
                xn = a > 4 || (a == 4 && !d[0]);
                q8 = !xn;
                qm[0] = d[0];
                for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
                a = $countones(qm);
                b = 8 - a;
                if (cin == 0 || a == b) begin
                    s.tmds = {~q8, q8, q8 ? qm : ~qm};
                    cout = cin + (q8 ? a - b : b - a);
                end else if ((cin > 0 && a > b) || (cin < 0 && b > a)) begin
                    s.tmds = {1'b1, q8, ~qm};
                    cout = cin + 2 * int'(q8) + b - a;
                end else begin
                    s.tmds = {1'b0, q8, qm};
                    cout = cin - 2 * int'(!q8) + a - b;
                end
            end
            3'd2: s.tmds = ch == 1 ? G1 : G0;
            3'd3: s.tmds = ch == 0 ? T4[{2'b11, c}] : G1;
            3'd4: s.tmds = T4[t];
            default: s.tmds = CC[c];
        endcase
        s.disp = 6'(cout);
        return s;
    endfunction
    task automatic chk(input string nm, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
        end
    endtask
    task automatic step(input logic [2:0] m, input logic [7:0] d, input logic [1:0] c, input logic [3:0] t, input logic r);
        int nc;
        sym_t e;
        mode = m; data = d; ctrl = c; terc = t; rst = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            cnt = 0;
            for (int u = 0; u < NU; u++)
                for (int j = 0; j < 16; j++) pipe[u][j] = '{CC[0], 6'sd0, 1'b0};
            armed = 1;
        end else begin
            for (int u = 0; u < NU; u++) begin
                for (int j = 15; j > 0; j--) pipe[u][j] = pipe[u][j-1];
                e = enc(CH[u], m, d, c, t, cnt, nc);
                pipe[u][0] = e;
            end
            cnt = nc;
        end
        #1;
        if (armed)
            for (int u = 0; u < NU; u++) begin
                e = pipe[u][LAT[u]-1];
                chk($sformatf("u%0d tmds", u), 32'(tm[u]), 32'(e.tmds));
                chk($sformatf("u%0d disparity", u), 32'(dp[u]), 32'(e.disp));
                chk($sformatf("u%0d mode_err", u), 32'(er[u]), 32'(e.err));
            end
    endtask
    initial begin
        tbl[0]  = '{3'd1, 8'h00, 2'd0, 4'h0, 10'b0100000000, -6'sd8, 1'b0};
        tbl[1]  = '{3'd1, 8'h00, 2'd0, 4'h0, 10'b1111111111,  6'sd2, 1'b0};
        tbl[2]  = '{3'd1, 8'h00, 2'd0, 4'h0, 10'b0100000000, -6'sd6, 1'b0};
        tbl[3]  = '{3'd1, 8'h00, 2'd0, 4'h0, 10'b1111111111,  6'sd4, 1'b0};
        tbl[4]  = '{3'd0, 8'h00, 2'd1, 4'h0, 10'b0010101011,  6'sd0, 1'b0};
        tbl[5]  = '{3'd1, 8'hFF, 2'd0, 4'h0, 10'b1000000000, -6'sd8, 1'b0};
        tbl[6]  = '{3'd4, 8'h00, 2'd0, 4'h0, 10'b1010011100,  6'sd0, 1'b0};
        tbl[7]  = '{3'd4, 8'h00, 2'd0, 4'hA, 10'b0110011100,  6'sd0, 1'b0};
        tbl[8]  = '{3'd4, 8'h00, 2'd0, 4'hF, 10'b1011000011,  6'sd0, 1'b0};
        tbl[9]  = '{3'd3, 8'h00, 2'd1, 4'h0, 10'b1001110001,  6'sd0, 1'b0};
        tbl[10] = '{3'd2, 8'h00, 2'd0, 4'h0, 10'b1011001100,  6'sd0, 1'b0};
        tbl[11] = '{3'd1, 8'h00, 2'd0, 4'h0, 10'b0100000000, -6'sd8, 1'b0};
        tbl[12] = '{3'd6, 8'h00, 2'd3, 4'h0, 10'b1010101011,  6'sd0, 1'b1};
        tbl[13] = '{3'd1, 8'h00, 2'd0, 4'h0, 10'b0100000000, -6'sd8, 1'b0};
        tbl[14] = '{3'd0, 8'h00, 2'd2, 4'h0, 10'b0101010100,  6'sd0, 1'b0};
        tbl[15] = '{3'd0, 8'h00, 2'd3, 4'h0, 10'b1010101011,  6'sd0, 1'b0};
        tbl[16] = '{3'd0, 8'h00, 2'd0, 4'h0, 10'b1101010100,  6'sd0, 1'b0};
        repeat (3) begin
            step(3'd0, 8'h00, 2'd0, 4'h0, 1'b1);
            chk("reset tmds", 32'(tm[3]), 32'(10'b1101010100));
            chk("reset disparity", 32'(dp[3]), 0);
        end
        repeat (10) step(3'd0, 8'h00, 2'd0, 4'h0, 1'b0);
        for (int i = 0; i < 17 + 3; i++) begin
            if (i < 17) step(tbl[i].m, tbl[i].d, tbl[i].c, tbl[i].t, 1'b0);
            else step(3'd0, 8'h00, 2'd0, 4'h0, 1'b0);
            if (i >= 3) begin
                chk($sformatf("vec%0d tmds", i - 3), 32'(tm[0]), 32'(tbl[i-3].x));
                chk($sformatf("vec%0d disparity", i - 3), 32'(dp[0]), 32'(tbl[i-3].p));
                chk($sformatf("vec%0d mode_err", i - 3), 32'(er[0]), 32'(tbl[i-3].e));
            end
        end
        repeat (6) step(3'd2, 8'h00, 2'd0, 4'h0, 1'b0);
        chk("ch1 video guard", 32'(tm[1]), 32'(10'b0100110011));
        repeat (6) step(3'd3, 8'h00, 2'd2, 4'h0, 1'b0);
        chk("ch1 island guard", 32'(tm[1]), 32'(10'b0100110011));
        for (int i = 0; i < 6; i++) step(3'd1, 8'(8'h10 + i), 2'd0, 4'h0, 1'b0);
        step(3'd1, 8'h00, 2'd0, 4'h0, 1'b1);
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("midreset u%0d tmds", u), 32'(tm[u]), 32'(10'b1101010100));
            chk($sformatf("midreset u%0d disparity", u), 32'(dp[u]), 0);
        end
        repeat (8) step(3'd1, 8'h00, 2'd0, 4'h0, 1'b0);
        for (int i = 0; i < 800; i++) begin
            logic [2:0] m;
            m = $urandom_range(0, 99) < 65 ? 3'd1 : 3'($urandom_range(0, 7));
            step(m, 8'($urandom), 2'($urandom), 4'($urandom), $urandom_range(0, 79) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tmds_multimode_encoder.md
# tmds_multimode_encoder

Single-lane TMDS encoder for HDMI output. It is the successor of the DVI-only video/control encoder and adds HDMI data-island support: TERC4 symbols, video and data-island guard bands, a parametrised channel identity and a configurable fixed pipeline latency. One instance drives each of the three data lanes ahead of the 10:1 serialiser. A packet/period scheduler upstream selects the mode every pixel clock.

## Interface
Parameters:
- CHANNEL, 0: lane index (0 = blue, 1 = green, 2 = red). Selects the guard-band codes.
- LATENCY, 4: cycles from input sample to `o_tmds`. Legal range is 3..16.

Ports (clock and reset first):
- i_hdmi_clk  in  1  pixel clock; one clock domain only.
- i_reset  in  1  synchronous, active-high reset.
- i_mode  in  3  symbol mode: 0 CTRL, 1 VIDEO, 2 VIDEO_GUARD, 3 ISLAND_GUARD, 4 TERC4; 5..7 are illegal.
- i_data  in  8  pixel byte; used in VIDEO mode only.
- i_ctrl  in  2  {c1,c0}, which is {vsync,hsync} on lane 0; used in CTRL mode, and in ISLAND_GUARD mode on lane 0.
- i_terc4  in  4  TERC4 nibble; used in TERC4 mode.
- o_tmds  out  10  encoded symbol; bit 0 is serialised first.
- o_disparity  out  6  signed running disparity (#ones − #zeros), valid after the symbol in `o_tmds`.
- o_mode_err  out  1  one-cycle pulse aligned with a symbol that was produced from an illegal mode.

## Operation
All codes below are written as bits 9..0.
- **CTRL:**
  - 00 → 1101010100
  - 01 → 0010101011
  - 10 → 0101010100
  - 11 → 1010101011
- **VIDEO:** DVI 1.0 8b/10b encoding.
  - N1 = popcount(i_data).
  - XNOR path when N1>4, or when N1==4 and d0==0; q_m[8]=0. Otherwise XOR path; q_m[8]=1.
  - q_m[0]=d0. For i=1..7, q_m[i] = q_m[i−1] XOR/XNOR d[i].
- **DC balance (VIDEO only).** n1/n0 are the ones/zeros counts of q_m[7:0]; cnt is the running disparity.
  - If cnt==0 or n1==n0: out = {~q_m8, q_m8, q_m8 ? q_m : ~q_m}; cnt += q_m8 ? (n1−n0) : (n0−n1).
  - Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1): out = {1, q_m8, ~q_m}; cnt += 2·q_m8 + (n0−n1).
  - Else: out = {0, q_m8, q_m}; cnt += −2·(~q_m8) + (n1−n0).
- **Disparity arithmetic:** 6-bit two's complement. |cnt| ≤ 8 is guaranteed by the algorithm, so no saturation logic is needed.
- **VIDEO_GUARD:**
  - Lanes 0 and 2 → 1011001100.
  - Lane 1 → 0100110011.
- **ISLAND_GUARD:**
  - Lanes 1 and 2 → 0100110011.
  - Lane 0 → the TERC4 code of {1,1,c1,c0}.
- **TERC4 table, indices 0..15:**
  - 0–3: 1010011100, 1001100011, 1011100100, 1011100010
  - 4–7: 0101110001, 0100011110, 0110001110, 0100111100
  - 8–11: 1011001100, 0100111001, 0110011100, 1011000110
  - 12–15: 1010001110, 1001110001, 0101100011, 1011000011
- **Disparity clearing:** any symbol whose mode is not VIDEO clears cnt to 0 in the same cycle that symbol is output.
- **Illegal mode:** the symbol is encoded as CTRL using i_ctrl, cnt is cleared, and `o_mode_err` is 1 for that symbol only.

## Timing
- **Pipeline:** fixed latency of LATENCY cycles for every mode. Inputs sampled at edge k appear on `o_tmds`, `o_disparity` and `o_mode_err` after edge k+LATENCY.
- **Stage structure:**
  - The input register is stage 1.
  - LATENCY−3 pure delay stages follow.
  - Then the q_m/popcount stage.
  - Then the balance/output-mux stage, which holds cnt.
  - All modes traverse the same stages, so mode changes never reorder or drop symbols.
- **Back-to-back modes:** any sequence is legal with no gap cycles. A VIDEO symbol immediately after a non-VIDEO symbol starts from cnt=0.
- **Reset:**
  - While `i_reset` is high at an edge, all pipeline stages load mode=CTRL, ctrl=00, err=0.
  - `o_tmds` = 1101010100, `o_disparity` = 0, `o_mode_err` = 0.
  - After release, the CTRL-00 code is output for LATENCY cycles, then the first sampled symbol appears.
- **Reset mid-stream:** reset asserted for one cycle during VIDEO forces the reset values on the next edge and discards all in-flight symbols.
- **No handshake:** the block consumes one symbol per cycle unconditionally.

## Test plan
- Reset held for 3 cycles, then CTRL 00 streamed → `o_tmds` = 1101010100 and `o_disparity` = 0 on every cycle, including the first LATENCY cycles after release.
- From cnt=0, VIDEO 0x00 ×4 → `o_tmds` sequence 0100000000, 1111111111, 0100000000, 1111111111, with `o_disparity` −8, +2, −6, +4. Each symbol appears exactly LATENCY cycles after its input.
- VIDEO 0x00 ×3, then CTRL 01, then VIDEO 0xFF → 0010101011 with disparity 0, then 1000000000 with disparity −8.
- TERC4 nibbles 0x0, 0xA, 0xF → 1010011100, 0110011100, 1011000011, each with disparity 0.
- CHANNEL=0, ISLAND_GUARD with i_ctrl=01 → 1001110001. CHANNEL=1 with VIDEO_GUARD → 0100110011, and with ISLAND_GUARD → 0100110011.
- i_mode=6 with i_ctrl=11 in the middle of a VIDEO stream → 1010101011, `o_mode_err` high for exactly one cycle, disparity 0, and the next VIDEO symbol encoded from cnt=0. Repeat with LATENCY=3 and LATENCY=7.
